// File: rtl/adc_device_emulator.sv
// Device-side responder for the 18-bit serial SAR ADC link: BUSY timing, MSB-first
// serial readout, sticky read-error flag, and an optional ramp test pattern.
module adc_device_emulator #(
  parameter int WIDTH             = 18,
  parameter int CONV_CYCLES       = 60,
  parameter int RESET_BUSY_CYCLES = 8,
  parameter int PATTERN_STEP      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pattern_en,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             RESET,
  input  logic             CNVST,
  input  logic             CS,
  input  logic             SCLK,
  output logic             BUSY,
  output logic             SDOUT,
  output logic             RDERROR,
  output logic [15:0]      conv_count,
  output logic             read_complete
);

  // state      | meaning
  // IDLE       | waiting for CNVST fall; serial readout allowed
  // DEVRESET   | RESET pin held high; BUSY low
  // RESET_BUSY | post-reset busy window after RESET pin release
  // CONV       | conversion in progress; BUSY high
  typedef enum logic [1:0] {IDLE, DEVRESET, RESET_BUSY, CONV} state_t;

  localparam int TMAX = (CONV_CYCLES > RESET_BUSY_CYCLES) ? CONV_CYCLES : RESET_BUSY_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int BW   = $clog2(WIDTH + 1);

  state_t           state, state_d;
  logic [TW-1:0]    timer, timer_d;
  logic             cnvst_q, sclk_q;
  logic [WIDTH-1:0] shreg, sample_q, ramp;
  logic [BW-1:0]    bit_cnt, bit_cnt_shift;
  logic             rderror;

  logic cnvst_fall, sclk_rise, busy, trigger, shift_en, end_conv, busy_err, read_err;

  assign cnvst_fall = cnvst_q & ~CNVST;
  assign sclk_rise  = ~sclk_q & SCLK;
  assign busy       = (state == CONV) || (state == RESET_BUSY);
  assign trigger    = (state == IDLE) && cnvst_fall;
  assign shift_en   = (state == IDLE) && sclk_rise && !CS;
  assign end_conv   = (state == CONV) && (timer == '0);

  // Shift is applied before the read-error check when both edges coincide.
  assign bit_cnt_shift = (shift_en && bit_cnt != BW'(WIDTH)) ? bit_cnt + 1'b1 : bit_cnt;
  assign busy_err      = cnvst_fall && busy;
  assign read_err      = trigger && !CS && (bit_cnt_shift != '0) && (bit_cnt_shift < BW'(WIDTH));

  assign BUSY    = busy;
  assign SDOUT   = !CS ? shreg[WIDTH-1] : 1'b0;
  assign RDERROR = rderror;

  always_comb begin
    state_d = state;
    timer_d = timer;
    if (RESET) begin
      state_d = DEVRESET;
    end else begin
      case (state)
        IDLE: if (trigger) begin
          state_d = CONV;
          timer_d = TW'(CONV_CYCLES - 1);
        end
        DEVRESET: begin
          state_d = RESET_BUSY;
          timer_d = TW'(RESET_BUSY_CYCLES - 1);
        end
        RESET_BUSY, CONV: begin
          if (timer == '0) state_d = IDLE;
          else timer_d = timer - 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      timer         <= '0;
      cnvst_q       <= 1'b1;
      sclk_q        <= 1'b1;
      shreg         <= '0;
      sample_q      <= '0;
      ramp          <= '0;
      bit_cnt       <= '0;
      rderror       <= 1'b0;
      conv_count    <= '0;
      read_complete <= 1'b0;
    end else begin
      state   <= state_d;
      timer   <= timer_d;
      cnvst_q <= CNVST;
      sclk_q  <= SCLK;
      if (RESET) begin
        rderror       <= 1'b0;
        bit_cnt       <= '0;
        read_complete <= 1'b0;
      end else begin
        read_complete <= shift_en && (bit_cnt == BW'(WIDTH - 1));
        bit_cnt       <= end_conv ? '0 : bit_cnt_shift;
        if (shift_en) shreg <= {shreg[WIDTH-2:0], 1'b0};
        if (end_conv) begin
          shreg      <= sample_q;
          conv_count <= conv_count + 16'd1;
        end
        if (trigger) begin
          sample_q <= pattern_en ? ramp : sample_in;
          if (pattern_en) ramp <= ramp + WIDTH'(PATTERN_STEP);
        end
        if (busy_err || read_err) rderror <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_adc_device_emulator.sv
// Self-checking bench for adc_device_emulator: acts as the host controller and checks
// against a transaction-level model of the device (expected sample, count, error flag).
module tb_adc_device_emulator;
  localparam int W = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          pattern_en;
  logic [W-1:0]  sample_in;
  logic          RESET, CNVST, CS, SCLK;
  logic          BUSY, SDOUT, RDERROR, read_complete;
  logic [15:0]   conv_count;

  int checks = 0;
  int errors = 0;

  // model state
  logic [W-1:0] m_ramp = '0;
  logic [W-1:0] m_exp;
  int           m_count = 0;
  int           m_bitcnt = 0;
  logic         m_rderr = 1'b0;

  adc_device_emulator dut (
    .clk(clk), .reset(reset), .pattern_en(pattern_en), .sample_in(sample_in),
    .RESET(RESET), .CNVST(CNVST), .CS(CS), .SCLK(SCLK),
    .BUSY(BUSY), .SDOUT(SDOUT), .RDERROR(RDERROR),
    .conv_count(conv_count), .read_complete(read_complete)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Release the RESET pin and measure the post-reset BUSY window.
  task automatic finish_reset(output int n);
    RESET = 1'b0;
    n = 0;
    tick();
    while (BUSY === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    m_rderr  = 1'b0;
    m_bitcnt = 0;
  endtask

  task automatic reset_pin(input int cycles, output int n);
    RESET = 1'b1;
    repeat (cycles) tick();
    chk("busy_during_reset_pin", {31'd0, BUSY}, 32'd0);
    finish_reset(n);
  endtask

  // Trigger a conversion and count BUSY-high cycles. Optional CNVST glitch or RESET
  // assertion at a given cycle of the conversion (0 = none).
  task automatic conv_wait(input logic pe, input logic [W-1:0] s,
                           input int glitch_at, input int reset_at, output int n);
    pattern_en = pe;
    sample_in  = s;
    m_exp = pe ? m_ramp : s;
    if (pe) m_ramp = m_ramp + 1'b1;
    if (CS == 1'b0 && m_bitcnt > 0 && m_bitcnt < W) m_rderr = 1'b1;
    n = 0;
    CNVST = 1'b0;
    tick();
    CNVST = 1'b1;
    while (BUSY === 1'b1 && n < 200) begin
      n++;
      if (glitch_at != 0 && n == glitch_at) CNVST = 1'b0;
      if (glitch_at != 0 && n == glitch_at + 1) CNVST = 1'b1;
      if (reset_at != 0 && n == reset_at) RESET = 1'b1;
      tick();
    end
    if (glitch_at != 0) m_rderr = 1'b1;
    if (reset_at == 0) begin
      m_count++;
      m_bitcnt = 0;
    end
  endtask

  // Host read of k bits; SDOUT captured at each SCLK rise, CS optionally left low.
  task automatic read_bits(input int k, input bit release_cs,
                           output logic [W-1:0] data, output int pulses);
    data = '0;
    pulses = 0;
    CS = 1'b0;
    tick();
    for (int i = 0; i < k; i++) begin
      SCLK = 1'b0;
      tick();
      pulses += int'(read_complete);
      SCLK = 1'b1;
      data = {data[W-2:0], SDOUT};
      tick();
      pulses += int'(read_complete);
    end
    tick();
    pulses += int'(read_complete);
    if (release_cs) CS = 1'b1;
    tick();
    m_bitcnt = (m_bitcnt + k > W) ? W : m_bitcnt + k;
  endtask

  initial begin
    int n, pulses, k;
    logic [W-1:0] data, s;
    logic pe;

    reset = 1'b0; pattern_en = 1'b0; sample_in = '0;
    RESET = 1'b0; CNVST = 1'b1; CS = 1'b1; SCLK = 1'b1;
    repeat (3) tick();
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_sdout", {31'd0, SDOUT}, 32'd0);
    chk("rst_rderror", {31'd0, RDERROR}, 32'd0);
    chk("rst_count", {16'd0, conv_count}, 32'd0);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n += int'(BUSY) + int'(read_complete);
    end
    chk("idle_no_activity", n, 0);

    reset_pin(3, n);
    chk("reset_busy_len", n, 8);

    conv_wait(1'b0, 18'h2A5C3, 0, 0, n);
    chk("conv_busy_len", n, 60);
    chk("sdout_cs_high", {31'd0, SDOUT}, 32'd0);
    read_bits(W, 1'b1, data, pulses);
    chk("read_2a5c3", data, 18'h2A5C3);
    chk("read_pulse_once", pulses, 1);
    chk("count_after_first", {16'd0, conv_count}, m_count);

    for (int j = 0; j < 3; j++) begin
      conv_wait(1'b1, 18'h3FFFF, 0, 0, n);
      read_bits(W, 1'b1, data, pulses);
      chk("ramp_value", data, m_exp);
    end
    chk("count_after_ramp", {16'd0, conv_count}, m_count);
    chk("rderror_clean", {31'd0, RDERROR}, {31'd0, m_rderr});

    // partial read then re-trigger with CS low
    conv_wait(1'b0, 18'h1B00F, 0, 0, n);
    read_bits(5, 1'b0, data, pulses);
    chk("partial5_bits", data, 18'h1B00F >> 13);
    conv_wait(1'b0, 18'h05A5A, 0, 0, n);
    chk("rderror_partial", {31'd0, RDERROR}, {31'd0, m_rderr});
    read_bits(W, 1'b1, data, pulses);
    chk("read_after_err", data, 18'h05A5A);
    chk("rderror_sticky", {31'd0, RDERROR}, 32'd1);
    reset_pin(2, n);
    chk("rderror_cleared", {31'd0, RDERROR}, 32'd0);

    // CNVST fall while busy
    conv_wait(1'b0, 18'h2FFFE, 30, 0, n);
    chk("glitch_busy_len", n, 60);
    chk("rderror_glitch", {31'd0, RDERROR}, {31'd0, m_rderr});
    chk("count_after_glitch", {16'd0, conv_count}, m_count);
    read_bits(W, 1'b1, data, pulses);
    chk("read_after_glitch", data, 18'h2FFFE);

    // RESET pin during conversion
    conv_wait(1'b0, 18'h11111, 0, 20, n);
    chk("abort_busy_drop", n, 20);
    chk("abort_busy_low", {31'd0, BUSY}, 32'd0);
    finish_reset(n);
    chk("abort_reset_busy_len", n, 8);
    chk("abort_count", {16'd0, conv_count}, m_count);
    chk("abort_rderror", {31'd0, RDERROR}, 32'd0);

    for (int j = 0; j < 10; j++) begin
      pe = 1'($urandom_range(0, 1));
      s = W'($urandom);
      conv_wait(pe, s, 0, 0, n);
      chk("rnd_busy_len", n, 60);
      k = $urandom_range(0, W);
      read_bits(k, 1'b0, data, pulses);
      if (k > 0) chk("rnd_data", data, m_exp >> (W - k));
      chk("rnd_pulses", pulses, (k == W) ? 1 : 0);
      chk("rnd_rderror", {31'd0, RDERROR}, {31'd0, m_rderr});
      chk("rnd_count", {16'd0, conv_count}, m_count);
    end
    CS = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
